// File: rtl/uart_msg_decoder.sv
// Decodes multiplayer UART bytes into one-hot command pulses, either as single
// characters or as checksummed SOF,CMD,ARG,CHK frames with inter-byte timeout.
module uart_msg_decoder #(
    parameter int unsigned              N_CMD     = 4,
    parameter logic [8*N_CMD-1:0]       CMD_CODES = (8*N_CMD)'(32'h50_52_48_4C),
    parameter int unsigned              FRAMED    = 1,
    parameter logic [7:0]               SOF       = 8'h3C,
    parameter int unsigned              TIMEOUT   = 50000,
    parameter int unsigned              CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             rx_done_tick,
    input  logic [7:0]       rx_data,
    output logic [N_CMD-1:0] cmd_hit,
    output logic [7:0]       cmd_arg,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    localparam int unsigned TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GET_CMD = 2'd1;
    localparam logic [1:0] S_GET_ARG = 2'd2;
    localparam logic [1:0] S_GET_CHK = 2'd3;

    localparam logic [1:0] E_CHECKSUM = 2'd1;
    localparam logic [1:0] E_UNKNOWN  = 2'd2;
    localparam logic [1:0] E_TIMEOUT  = 2'd3;

    logic [1:0]         state_q,    state_d;
    logic [TIMER_W-1:0] timer_q,    timer_d;
    logic [7:0]         cmd_q,      cmd_d;
    logic [7:0]         arg_q,      arg_d;
    logic [N_CMD-1:0]   cmd_hit_q,  cmd_hit_d;
    logic [7:0]         cmd_arg_q,  cmd_arg_d;
    logic               err_q,      err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [CNT_W-1:0]   err_cnt_q,  err_cnt_d;
    logic               busy_q,     busy_d;

    logic [7:0]         lookup_byte;
    logic [N_CMD-1:0]   hit_vec;
    logic               hit_any;

    // Code lookup; scanning downward lets the lowest index win on duplicates.
    always_comb begin
        lookup_byte = (FRAMED != 0) ? cmd_q : rx_data;
        hit_vec     = '0;
        for (int i = N_CMD - 1; i >= 0; i--) begin
            if (lookup_byte == CMD_CODES[8*i +: 8]) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
            end
        end
        hit_any = |hit_vec;
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        cmd_hit_d  = '0;
        cmd_arg_d  = cmd_arg_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        err_cnt_d  = err_cnt_q;

        if (!enable) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else if (FRAMED == 0) begin
            if (rx_done_tick && hit_any) begin
                cmd_hit_d = hit_vec;
                cmd_arg_d = 8'h00;
            end
        end else begin
            if (rx_done_tick || state_q == S_IDLE) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + TIMER_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (rx_done_tick && rx_data == SOF) begin
                        state_d = S_GET_CMD;
                    end
                end
                S_GET_CMD: begin
                    // A repeated SOF restarts the frame instead of being taken as a command.
                    if (rx_done_tick && rx_data != SOF) begin
                        cmd_d   = rx_data;
                        state_d = S_GET_ARG;
                    end
                end
                S_GET_ARG: begin
                    if (rx_done_tick) begin
                        arg_d   = rx_data;
                        state_d = S_GET_CHK;
                    end
                end
                S_GET_CHK: begin
                    if (rx_done_tick) begin
                        state_d = S_IDLE;
                        if (rx_data != (cmd_q ^ arg_q)) begin
                            err_d      = 1'b1;
                            err_code_d = E_CHECKSUM;
                        end else if (hit_any) begin
                            cmd_hit_d = hit_vec;
                            cmd_arg_d = arg_q;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = E_UNKNOWN;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A tick arriving on the last allowed cycle takes priority over the timeout.
            if (!rx_done_tick && state_q != S_IDLE && timer_q == TIMER_W'(TIMEOUT - 1)) begin
                state_d    = S_IDLE;
                timer_d    = '0;
                err_d      = 1'b1;
                err_code_d = E_TIMEOUT;
            end
        end

        if (err_d && err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            cmd_q      <= '0;
            arg_q      <= '0;
            cmd_hit_q  <= '0;
            cmd_arg_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            err_cnt_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            cmd_hit_q  <= cmd_hit_d;
            cmd_arg_q  <= cmd_arg_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_cnt_q  <= err_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign cmd_hit  = cmd_hit_q;
    assign cmd_arg  = cmd_arg_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign err_cnt  = err_cnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_msg_decoder.sv
// Directed bench for uart_msg_decoder: a framed instance (short timeout) and a
// single-char instance share the same byte stream.
module tb_uart_msg_decoder;

    localparam int unsigned TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rx_done_tick;
    logic [7:0] rx_data;

    logic [3:0] cmd_hit,  sc_cmd_hit;
    logic [7:0] cmd_arg,  sc_cmd_arg;
    logic       err,      sc_err;
    logic [1:0] err_code, sc_err_code;
    logic [7:0] err_cnt,  sc_err_cnt;
    logic       busy,     sc_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_msg_decoder #(.FRAMED(1), .TIMEOUT(TIMEOUT), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .cmd_hit(cmd_hit), .cmd_arg(cmd_arg), .err(err), .err_code(err_code),
        .err_cnt(err_cnt), .busy(busy)
    );

    uart_msg_decoder #(.FRAMED(0), .TIMEOUT(TIMEOUT), .CNT_W(8)) u_sc (
        .clk(clk), .rst(rst), .enable(enable), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .cmd_hit(sc_cmd_hit), .cmd_arg(sc_cmd_arg), .err(sc_err), .err_code(sc_err_code),
        .err_cnt(sc_err_cnt), .busy(sc_busy)
    );

    // Called at a negedge; holds the tick for exactly one posedge and returns at the next negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_data      = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({cmd_hit, cmd_arg, err, err_code, err_cnt, busy} !== 24'h0) begin
            errors++;
            $display("FAIL reset_framed: got %h expected 000000",
                     {cmd_hit, cmd_arg, err, err_code, err_cnt, busy});
        end
        checks++;
        if ({sc_cmd_hit, sc_cmd_arg, sc_err, sc_err_code, sc_err_cnt, sc_busy} !== 24'h0) begin
            errors++;
            $display("FAIL reset_single: got %h expected 000000",
                     {sc_cmd_hit, sc_cmd_arg, sc_err, sc_err_code, sc_err_cnt, sc_busy});
        end
    endtask

    task automatic test_single_char;
        send_byte(8'h4C);
        checks++;
        if (sc_cmd_hit !== 4'b0001) begin
            errors++; $display("FAIL single_L: got %b expected 0001", sc_cmd_hit);
        end
        @(negedge clk);
        checks++;
        if (sc_cmd_hit !== 4'b0000) begin
            errors++; $display("FAIL single_pulse_width: got %b expected 0000", sc_cmd_hit);
        end
        send_byte(8'h41);
        checks++;
        if (sc_cmd_hit !== 4'b0000 || sc_err !== 1'b0) begin
            errors++; $display("FAIL single_unknown: got hit=%b err=%b expected 0000/0", sc_cmd_hit, sc_err);
        end
        send_byte(8'h50);
        checks++;
        if (sc_cmd_hit !== 4'b1000 || sc_cmd_arg !== 8'h00) begin
            errors++; $display("FAIL single_P: got hit=%b arg=%h expected 1000/00", sc_cmd_hit, sc_cmd_arg);
        end
    endtask

    task automatic test_good_frame;
        send_byte(8'h3C);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_mid_frame: got %b expected 1", busy);
        end
        send_byte(8'h48); send_byte(8'h05); send_byte(8'h4D);
        checks++;
        if (cmd_hit !== 4'b0010 || cmd_arg !== 8'h05 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL good_frame_H: got hit=%b arg=%h err=%b busy=%b expected 0010/05/0/0",
                     cmd_hit, cmd_arg, err, busy);
        end
    endtask

    task automatic test_errors;
        send_byte(8'h3C); send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd1 || err_cnt !== 8'd1 || cmd_hit !== 4'b0000) begin
            errors++;
            $display("FAIL checksum_err: got err=%b code=%0d cnt=%0d hit=%b expected 1/1/1/0000",
                     err, err_code, err_cnt, cmd_hit);
        end
        send_byte(8'h3C); send_byte(8'h41); send_byte(8'h01); send_byte(8'h40);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || err_cnt !== 8'd2 || cmd_arg !== 8'h05) begin
            errors++;
            $display("FAIL unknown_cmd_err: got err=%b code=%0d cnt=%0d arg=%h expected 1/2/2/05",
                     err, err_code, err_cnt, cmd_arg);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || err_code !== 2'd2) begin
            errors++; $display("FAIL err_pulse_hold: got err=%b code=%0d expected 0/2", err, err_code);
        end
    endtask

    task automatic test_timeout;
        int waited;
        waited = 0;
        send_byte(8'h3C); send_byte(8'h4C);
        while (err !== 1'b1 && waited < 4 * TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited != TIMEOUT) begin
            errors++; $display("FAIL timeout_latency: got %0d cycles expected %0d", waited, TIMEOUT);
        end
        checks++;
        if (err_code !== 2'd3 || err_cnt !== 8'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: got code=%0d cnt=%0d busy=%b expected 3/3/0", err_code, err_cnt, busy);
        end
        send_byte(8'h3C); send_byte(8'h52); send_byte(8'h09); send_byte(8'h5B);
        checks++;
        if (cmd_hit !== 4'b0100 || cmd_arg !== 8'h09) begin
            errors++; $display("FAIL after_timeout_frame: got hit=%b arg=%h expected 0100/09", cmd_hit, cmd_arg);
        end
        // Byte arriving on the last permitted cycle must be accepted.
        send_byte(8'h3C); send_byte(8'h4C);
        repeat (TIMEOUT - 1) @(negedge clk);
        send_byte(8'h02); send_byte(8'h4E);
        checks++;
        if (cmd_hit !== 4'b0001 || cmd_arg !== 8'h02 || err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL tick_beats_timeout: got hit=%b arg=%h cnt=%0d expected 0001/02/3",
                     cmd_hit, cmd_arg, err_cnt);
        end
    endtask

    task automatic test_resync;
        send_byte(8'h3C); send_byte(8'h3C); send_byte(8'h50); send_byte(8'h07); send_byte(8'h57);
        checks++;
        if (cmd_hit !== 4'b1000 || cmd_arg !== 8'h07 || err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL resync: got hit=%b arg=%h cnt=%0d expected 1000/07/3", cmd_hit, cmd_arg, err_cnt);
        end
    endtask

    task automatic test_enable;
        logic [3:0] hits_or;
        logic       errs_or;
        send_byte(8'h3C); send_byte(8'h48);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL disable_abort: got busy=%b err=%b expected 0/0", busy, err);
        end
        send_byte(8'h4C);
        checks++;
        if (sc_cmd_hit !== 4'b0000 || cmd_hit !== 4'b0000) begin
            errors++; $display("FAIL disabled_ignore: got sc=%b fr=%b expected 0000/0000", sc_cmd_hit, cmd_hit);
        end
        checks++;
        if (cmd_arg !== 8'h07 || err_code !== 2'd3 || err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL disabled_hold: got arg=%h code=%0d cnt=%0d expected 07/3/3", cmd_arg, err_code, err_cnt);
        end
        enable = 1'b1;
        hits_or = '0; errs_or = 1'b0;
        send_byte(8'h05); hits_or |= cmd_hit; errs_or |= err;
        send_byte(8'h4D); hits_or |= cmd_hit; errs_or |= err;
        checks++;
        if (hits_or !== 4'b0000 || errs_or !== 1'b0) begin
            errors++; $display("FAIL stale_frame_discard: got hit=%b err=%b expected 0000/0", hits_or, errs_or);
        end
    endtask

    task automatic test_reset_mid_frame;
        send_byte(8'h3C); send_byte(8'h48);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({cmd_hit, cmd_arg, err, err_code, err_cnt, busy} !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid_frame: got %h expected 000000",
                     {cmd_hit, cmd_arg, err, err_code, err_cnt, busy});
        end
    endtask

    task automatic test_back_to_back;
        send_byte(8'h3C); send_byte(8'h48); send_byte(8'h01); send_byte(8'h49);
        checks++;
        if (cmd_hit !== 4'b0010 || cmd_arg !== 8'h01) begin
            errors++; $display("FAIL b2b_first: got hit=%b arg=%h expected 0010/01", cmd_hit, cmd_arg);
        end
        send_byte(8'h3C); send_byte(8'h4C); send_byte(8'h02); send_byte(8'h4E);
        checks++;
        if (cmd_hit !== 4'b0001 || cmd_arg !== 8'h02 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL b2b_second: got hit=%b arg=%h cnt=%0d expected 0001/02/0", cmd_hit, cmd_arg, err_cnt);
        end
    endtask

    task automatic test_err_saturation;
        for (int n = 0; n < 300; n++) begin
            send_byte(8'h3C); send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
            if (n == 254) begin
                checks++;
                if (err_cnt !== 8'd255) begin
                    errors++; $display("FAIL err_cnt_reach_max: got %0d expected 255", err_cnt);
                end
            end
        end
        checks++;
        if (err_cnt !== 8'd255 || err !== 1'b1 || err_code !== 2'd1) begin
            errors++;
            $display("FAIL err_cnt_saturate: got cnt=%0d err=%b code=%0d expected 255/1/1", err_cnt, err, err_code);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single_char;
        test_good_frame;
        test_errors;
        test_timeout;
        test_resync;
        test_enable;
        test_reset_mid_frame;
        test_back_to_back;
        test_err_saturation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
